// File: rtl/weight_bias_loader.sv
// Streams weight/bias words into every neuron of one layer, tagging each word
// with layer and neuron number on the neuron configuration bus.
module weight_bias_loader #(
  parameter int layerNo    = 2,
  parameter int numNeurons = 30,
  parameter int numWeight  = 30,
  parameter int LOAD_BIAS  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        weightValid,
  output logic        biasValid,
  output logic [31:0] weightValue,
  output logic [31:0] biasValue,
  output logic [31:0] config_layer_num,
  output logic [31:0] config_neuron_num,
  output logic        busy,
  output logic        done
);

  localparam int NW = $clog2(numNeurons) + 1;
  localparam int WW = $clog2(numWeight) + 1;
  localparam logic [NW-1:0] N_LAST = NW'(numNeurons - 1);
  localparam logic [WW-1:0] W_LAST = WW'(numWeight - 1);

  typedef enum logic [1:0] {IDLE, WEIGHT, BIAS, DONE} state_t;

  state_t      state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic [WW-1:0] w_q, w_d;
  logic        weight_valid_q, weight_valid_d;
  logic        bias_valid_q, bias_valid_d;
  logic [31:0] weight_value_q, weight_value_d;
  logic [31:0] bias_value_q, bias_value_d;
  logic [31:0] layer_q, layer_d;
  logic [31:0] neuron_q, neuron_d;
  logic        done_q, done_d;
  logic        hs;

  // Stream handshake: a word transfers on every rising edge where s_valid and
  // s_ready are both high; s_ready depends only on state, never on s_valid.
  assign s_ready = (state_q == WEIGHT) || (state_q == BIAS);
  assign hs      = s_valid & s_ready;

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    w_d            = w_q;
    weight_valid_d = 1'b0;
    bias_valid_d   = 1'b0;
    weight_value_d = weight_value_q;
    bias_value_d   = bias_value_q;
    layer_d        = 32'd0;
    neuron_d       = neuron_q;
    done_d         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WEIGHT;
          n_d     = '0;
          w_d     = '0;
        end
      end
      WEIGHT: begin
        if (hs) begin
          weight_valid_d = 1'b1;
          weight_value_d = s_data;
          layer_d        = 32'(layerNo);
          neuron_d       = 32'(n_q);
          w_d            = w_q + 1'b1;
          if (w_q == W_LAST) begin
            if (LOAD_BIAS != 0) begin
              state_d = BIAS;
            end else if (n_q == N_LAST) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              n_d = n_q + 1'b1;
              w_d = '0;
            end
          end
        end
      end
      BIAS: begin
        if (hs) begin
          bias_valid_d = 1'b1;
          bias_value_d = s_data;
          layer_d      = 32'(layerNo);
          neuron_d     = 32'(n_q);
          if (n_q == N_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = WEIGHT;
            n_d     = n_q + 1'b1;
            w_d     = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      n_q            <= '0;
      w_q            <= '0;
      weight_valid_q <= 1'b0;
      bias_valid_q   <= 1'b0;
      weight_value_q <= 32'd0;
      bias_value_q   <= 32'd0;
      layer_q        <= 32'd0;
      neuron_q       <= 32'd0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      w_q            <= w_d;
      weight_valid_q <= weight_valid_d;
      bias_valid_q   <= bias_valid_d;
      weight_value_q <= weight_value_d;
      bias_value_q   <= bias_value_d;
      layer_q        <= layer_d;
      neuron_q       <= neuron_d;
      done_q         <= done_d;
    end
  end

  assign weightValid       = weight_valid_q;
  assign biasValid         = bias_valid_q;
  assign weightValue       = weight_value_q;
  assign biasValue         = bias_value_q;
  assign config_layer_num  = layer_q;
  assign config_neuron_num = neuron_q;
  assign busy              = (state_q != IDLE);
  assign done              = done_q;

endmodule

// File: tb/tb_weight_bias_loader.sv
// Bench for weight_bias_loader: two configurations checked every cycle against a
// word-count model, plus literal strobe sequences per directed scenario.
module tb_weight_bias_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_i[2], s_valid_i[2];
  logic [31:0] s_data_i[2];
  logic        rdy_o[2], wv_o[2], bv_o[2], busy_o[2], done_o[2];
  logic [31:0] wval_o[2], bval_o[2], lay_o[2], neu_o[2];

  weight_bias_loader #(.layerNo(2), .numNeurons(2), .numWeight(3), .LOAD_BIAS(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_i[0]), .s_data(s_data_i[0]), .s_valid(s_valid_i[0]),
    .s_ready(rdy_o[0]), .weightValid(wv_o[0]), .biasValid(bv_o[0]), .weightValue(wval_o[0]),
    .biasValue(bval_o[0]), .config_layer_num(lay_o[0]), .config_neuron_num(neu_o[0]),
    .busy(busy_o[0]), .done(done_o[0])
  );

  weight_bias_loader #(.layerNo(2), .numNeurons(3), .numWeight(1), .LOAD_BIAS(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_i[1]), .s_data(s_data_i[1]), .s_valid(s_valid_i[1]),
    .s_ready(rdy_o[1]), .weightValid(wv_o[1]), .biasValid(bv_o[1]), .weightValue(wval_o[1]),
    .biasValue(bval_o[1]), .config_layer_num(lay_o[1]), .config_neuron_num(neu_o[1]),
    .busy(busy_o[1]), .done(done_o[1])
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Model: a load is just "accept tot words; word k goes to neuron k/per,
  // and is a bias when its position inside the neuron reaches nw".
  function automatic int per_of(input int i); return (i == 0) ? 4 : 1; endfunction
  function automatic int nw_of(input int i);  return (i == 0) ? 3 : 1; endfunction
  function automatic int tot_of(input int i); return (i == 0) ? 8 : 3; endfunction

  int          ph[2];
  int          k[2];
  bit          primed = 1'b0;
  logic        exp_wv[2], exp_bv[2], exp_done[2], exp_busy[2], exp_rdy[2];
  logic [31:0] exp_wval[2], exp_bval[2], exp_lay[2], exp_neu[2];

  int          sel = 0;
  logic [39:0] obs_q[$];
  int          obs_cyc_q[$];
  logic [39:0] exp_q[$];
  int          done_cnt = 0;
  int          done_cyc = -1;

  always @(negedge clk) begin
    cyc++;
    if (primed) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("i%0d_weightValid", i), 40'(wv_o[i]), 40'(exp_wv[i]));
        chk($sformatf("i%0d_biasValid", i), 40'(bv_o[i]), 40'(exp_bv[i]));
        chk($sformatf("i%0d_weightValue", i), 40'(wval_o[i]), 40'(exp_wval[i]));
        chk($sformatf("i%0d_biasValue", i), 40'(bval_o[i]), 40'(exp_bval[i]));
        chk($sformatf("i%0d_layer", i), 40'(lay_o[i]), 40'(exp_lay[i]));
        chk($sformatf("i%0d_neuron", i), 40'(neu_o[i]), 40'(exp_neu[i]));
        chk($sformatf("i%0d_done", i), 40'(done_o[i]), 40'(exp_done[i]));
        chk($sformatf("i%0d_busy", i), 40'(busy_o[i]), 40'(exp_busy[i]));
        chk($sformatf("i%0d_s_ready", i), 40'(rdy_o[i]), 40'(exp_rdy[i]));
      end
    end
    if (wv_o[sel] || bv_o[sel]) begin
      obs_q.push_back({8'(bv_o[sel]), 8'(neu_o[sel]), 24'(bv_o[sel] ? bval_o[sel] : wval_o[sel])});
      obs_cyc_q.push_back(cyc);
    end
    if (done_o[sel]) begin
      done_cnt++;
      done_cyc = cyc;
    end
    // advance the model with the inputs the next rising edge will sample
    for (int i = 0; i < 2; i++) begin
      exp_wv[i]   = 1'b0;
      exp_bv[i]   = 1'b0;
      exp_lay[i]  = 32'd0;
      exp_done[i] = 1'b0;
      if (rst) begin
        ph[i] = 0; k[i] = 0;
        exp_wval[i] = 32'd0; exp_bval[i] = 32'd0; exp_neu[i] = 32'd0;
      end else if (ph[i] == 0) begin
        if (start_i[i]) begin ph[i] = 1; k[i] = 0; end
      end else if (ph[i] == 1) begin
        if (s_valid_i[i]) begin
          if ((k[i] % per_of(i)) < nw_of(i)) begin
            exp_wv[i] = 1'b1; exp_wval[i] = s_data_i[i];
          end else begin
            exp_bv[i] = 1'b1; exp_bval[i] = s_data_i[i];
          end
          exp_lay[i] = 32'd2;
          exp_neu[i] = 32'(k[i] / per_of(i));
          k[i]++;
          if (k[i] == tot_of(i)) begin ph[i] = 2; exp_done[i] = 1'b1; end
        end
      end else begin
        ph[i] = 0;
      end
      exp_busy[i] = (ph[i] != 0);
      exp_rdy[i]  = (ph[i] == 1);
    end
    primed = 1'b1;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int i);
    start_i[i] = 1'b1;
    cycles(1);
    start_i[i] = 1'b0;
  endtask

  task automatic stream(input int i, input int first, input int count, input bit gap, input int start_at);
    bit acc;
    int tmo;
    for (int w = 0; w < count; w++) begin
      if (gap && w > 0) begin
        s_valid_i[i] = 1'b0;
        cycles(1);
      end
      s_valid_i[i] = 1'b1;
      s_data_i[i]  = 32'(first + w);
      if (w == start_at) start_i[i] = 1'b1;
      tmo = 0;
      do begin
        @(negedge clk);
        acc = rdy_o[i];
        cycles(1);
        start_i[i] = 1'b0;
        tmo++;
      end while (!acc && tmo < 20);
      chk($sformatf("i%0d_accept_w%0d", i, w), 40'(acc), 40'd1);
      if (!acc) break;
    end
    s_valid_i[i] = 1'b0;
  endtask

  // hold s_valid high after the load so any extra acceptance would show up
  task automatic extra_words(input int i);
    s_valid_i[i] = 1'b1;
    s_data_i[i]  = 32'hDEAD;
    cycles(3);
    s_valid_i[i] = 1'b0;
    cycles(1);
  endtask

  task automatic lit(input bit b, input int neu, input int val);
    exp_q.push_back({8'(b), 8'(neu), 24'(val)});
  endtask

  task automatic lit_full(input int first);
    for (int j = 0; j < 8; j++) lit((j % 4) == 3, j / 4, first + j);
  endtask

  task automatic lit_compare(input string tag, input int spacing, input int exp_done_n);
    chk({tag, "_count"}, 40'(obs_q.size()), 40'(exp_q.size()));
    for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++) begin
      chk($sformatf("%s_word%0d", tag, j), obs_q[j], exp_q[j]);
      if (j > 0) chk($sformatf("%s_gap%0d", tag, j), 40'(obs_cyc_q[j] - obs_cyc_q[j-1]), 40'(spacing));
    end
    chk({tag, "_done_count"}, 40'(done_cnt), 40'(exp_done_n));
    if (exp_done_n > 0 && obs_cyc_q.size() > 0)
      chk({tag, "_done_with_last"}, 40'(done_cyc), 40'(obs_cyc_q[obs_cyc_q.size()-1]));
    obs_q.delete();
    obs_cyc_q.delete();
    exp_q.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      start_i[i] = 1'b0; s_valid_i[i] = 1'b0; s_data_i[i] = 32'd0;
    end
    cycles(3);
    rst = 1'b0;
    chk("reset_busy", 40'(busy_o[0]), 40'd0);
    chk("reset_layer", 40'(lay_o[0]), 40'd0);

    // s_valid while idle with no start
    s_valid_i[0] = 1'b1; s_valid_i[1] = 1'b1;
    s_data_i[0] = 32'd99; s_data_i[1] = 32'd99;
    cycles(4);
    chk("idle_ready", 40'(rdy_o[0]), 40'd0);
    s_valid_i[0] = 1'b0; s_valid_i[1] = 1'b0;
    cycles(1);
    lit_compare("idle", 1, 0);

    // back-to-back stream 1..8
    lit_full(1);
    pulse_start(0);
    stream(0, 1, 8, 1'b0, -1);
    extra_words(0);
    lit_compare("b2b", 1, 1);

    // s_valid toggling every other cycle
    lit_full(1);
    pulse_start(0);
    stream(0, 1, 8, 1'b1, -1);
    extra_words(0);
    lit_compare("gap", 2, 1);

    // weights only, three neurons of one weight
    sel = 1;
    lit(1'b0, 0, 'hA); lit(1'b0, 1, 'hB); lit(1'b0, 2, 'hC);
    pulse_start(1);
    stream(1, 'hA, 3, 1'b0, -1);
    extra_words(1);
    lit_compare("nobias", 1, 1);
    sel = 0;

    // start pulsed at word 3 and again during DONE
    lit_full(1);
    pulse_start(0);
    stream(0, 1, 8, 1'b0, 2);
    start_i[0] = 1'b1;
    cycles(1);
    start_i[0] = 1'b0;
    chk("done_start_ignored", 40'(busy_o[0]), 40'd0);
    extra_words(0);
    lit_compare("restart", 1, 1);

    // reset after word 5 with word 6 on the bus
    for (int j = 0; j < 5; j++) lit((j % 4) == 3, j / 4, 1 + j);
    pulse_start(0);
    stream(0, 1, 5, 1'b0, -1);
    s_valid_i[0] = 1'b1;
    s_data_i[0]  = 32'd6;
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    s_valid_i[0] = 1'b0;
    chk("rst_busy", 40'(busy_o[0]), 40'd0);
    chk("rst_ready", 40'(rdy_o[0]), 40'd0);
    chk("rst_strobe", 40'(wv_o[0] | bv_o[0]), 40'd0);
    cycles(2);
    lit_compare("rst_pre", 1, 0);
    lit_full(1);
    pulse_start(0);
    stream(0, 1, 8, 1'b0, -1);
    extra_words(0);
    lit_compare("rst_reload", 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
